// File: rtl/lc_pkg.sv
// ---------------------------------------------------------------------------
// lc_pkg : shared types and constants for the lifecycle-transition initiator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef LC_MEMORY_WIDTH
`define LC_MEMORY_WIDTH 64
`endif

package lc_pkg;

  typedef enum logic [2:0] {
    STATUS_OK        = 3'd0,
    STATUS_AUTH_FAIL = 3'd1,
    STATUS_STALE     = 3'd2,
    STATUS_EOL       = 3'd3,
    STATUS_LOCKED    = 3'd4,
    STATUS_TIMEOUT   = 3'd5
  } lc_status_t;

  typedef enum logic [2:0] {
    INIT_IDLE    = 3'd0,
    INIT_REQ     = 3'd1,
    INIT_RELEASE = 3'd2,
    INIT_RESP    = 3'd3,
    INIT_FAULT   = 3'd4
  } lc_init_state_t;

  localparam logic [2:0] LC_STATE_RESET = 3'd1;
  localparam logic [2:0] LC_STATE_EOL   = 3'd5;

  // A transition only counts if the protection block landed exactly one step on.
  function automatic logic transition_ok(input logic       success,
                                         input logic [2:0] got_state,
                                         input logic [2:0] exp_state);
    return success && (got_state == exp_state + 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc_timeout_timer.sv
// ---------------------------------------------------------------------------
// lc_timeout_timer : saturating cycle counter flagging the last allowed cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lc_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned   c_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT_CYCLES - 1);

  logic [c_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry marks the TIMEOUT_CYCLES-th enabled cycle, so the caller leaves on that edge.
  assign o_expire = i_enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/lc_transition_initiator.sv
// ---------------------------------------------------------------------------
// lc_transition_initiator : screens transition commands, runs the request
// handshake to the protection block, enforces lockout and timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lc_transition_initiator
  import lc_pkg::*;
#(
  parameter int unsigned LC_MEMORY_WIDTH = `LC_MEMORY_WIDTH,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [LC_MEMORY_WIDTH-1:0] cmd_identifier,
  input  logic [2:0]                 cmd_expected_state,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_status,
  output logic [2:0]                 rsp_state,
  output logic                       locked,
  output logic                       fault,
  output logic                       lc_transition_request,
  output logic [LC_MEMORY_WIDTH-1:0] lc_identifier,
  input  logic                       lc_done,
  input  logic                       lc_success,
  input  logic [2:0]                 lc_state
);

  localparam logic [3:0] c_max_fails = 4'(MAX_FAILS);

  lc_init_state_t             r_state,     w_state_nxt;
  logic [LC_MEMORY_WIDTH-1:0] r_id,        w_id_nxt;
  logic [2:0]                 r_exp,       w_exp_nxt;
  logic                       r_succ,      w_succ_nxt;
  logic [2:0]                 r_rsp_state, w_rsp_state_nxt;
  lc_status_t                 r_status,    w_status_nxt;
  logic                       r_rsp_valid, w_rsp_valid_nxt;
  logic [3:0]                 r_fail_cnt,  w_fail_cnt_nxt;
  logic                       r_locked,    w_locked_nxt;
  logic                       r_fault,     w_fault_nxt;

  logic       w_timer_clr;
  logic       w_timer_en;
  logic       w_expire;
  logic [3:0] w_fail_inc;

  assign w_timer_en = (r_state == INIT_REQ) || (r_state == INIT_RELEASE);
  assign w_fail_inc = (r_fail_cnt == c_max_fails) ? r_fail_cnt : r_fail_cnt + 4'd1;

  lc_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_id_nxt        = r_id;
    w_exp_nxt       = r_exp;
    w_succ_nxt      = r_succ;
    w_rsp_state_nxt = r_rsp_state;
    w_status_nxt    = r_status;
    w_rsp_valid_nxt = r_rsp_valid;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_locked_nxt    = r_locked;
    w_fault_nxt     = r_fault;
    w_timer_clr     = 1'b0;

    case (r_state)
      INIT_IDLE: begin
        if (cmd_valid) begin
          w_rsp_state_nxt = lc_state;
          if (r_locked) begin
            w_status_nxt    = STATUS_LOCKED;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = INIT_RESP;
          end else if (lc_state != cmd_expected_state) begin
            w_status_nxt    = STATUS_STALE;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = INIT_RESP;
          end else if (lc_state >= LC_STATE_EOL) begin
            w_status_nxt    = STATUS_EOL;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = INIT_RESP;
          end else begin
            w_id_nxt    = cmd_identifier;
            w_exp_nxt   = cmd_expected_state;
            w_timer_clr = 1'b1;
            w_state_nxt = INIT_REQ;
          end
        end
      end

      INIT_REQ: begin
        // Completion takes priority over a coincident timer expiry.
        if (lc_done) begin
          w_succ_nxt      = lc_success;
          w_rsp_state_nxt = lc_state;
          w_id_nxt        = '0;
          w_state_nxt     = INIT_RELEASE;
        end else if (w_expire) begin
          w_id_nxt        = '0;
          w_fault_nxt     = 1'b1;
          w_status_nxt    = STATUS_TIMEOUT;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = INIT_FAULT;
        end
      end

      INIT_RELEASE: begin
        w_id_nxt = '0;
        if (!lc_done) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = INIT_RESP;
          if (transition_ok(r_succ, r_rsp_state, r_exp)) begin
            w_status_nxt   = STATUS_OK;
            w_fail_cnt_nxt = 4'd0;
          end else begin
            w_status_nxt   = STATUS_AUTH_FAIL;
            w_fail_cnt_nxt = w_fail_inc;
            w_locked_nxt   = r_locked | (w_fail_inc == c_max_fails);
          end
        end else if (w_expire) begin
          w_fault_nxt     = 1'b1;
          w_status_nxt    = STATUS_TIMEOUT;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = INIT_FAULT;
        end
      end

      INIT_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = INIT_IDLE;
        end
      end

      INIT_FAULT: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = INIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_IDLE;
      r_id        <= '0;
      r_exp       <= 3'd0;
      r_succ      <= 1'b0;
      r_rsp_state <= 3'd0;
      r_status    <= STATUS_OK;
      r_rsp_valid <= 1'b0;
      r_fail_cnt  <= 4'd0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_exp       <= w_exp_nxt;
      r_succ      <= w_succ_nxt;
      r_rsp_state <= w_rsp_state_nxt;
      r_status    <= w_status_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_locked    <= w_locked_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign cmd_ready             = (r_state == INIT_IDLE);
  assign lc_transition_request = (r_state == INIT_REQ);
  assign lc_identifier         = r_id;
  assign rsp_valid             = r_rsp_valid;
  assign rsp_status            = r_status;
  assign rsp_state             = r_rsp_state;
  assign locked                = r_locked;
  assign fault                 = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_lc_transition_initiator.sv
// ---------------------------------------------------------------------------
// tb_lc_transition_initiator : vector table, corner sequences and randomized
// commands against a rule-level model with a behavioural protection block.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lc_transition_initiator;

  localparam int W        = 32;
  localparam int MAXF     = 3;
  localparam int TMO      = 16;
  localparam int S_OK     = 0;
  localparam int S_AUTH   = 1;
  localparam int S_STALE  = 2;
  localparam int S_EOL    = 3;
  localparam int S_LOCKED = 4;
  localparam int S_TMO    = 5;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_identifier;
  logic [2:0]   cmd_expected_state;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2:0]   rsp_status;
  logic [2:0]   rsp_state;
  logic         locked;
  logic         fault;
  logic         lc_transition_request;
  logic [W-1:0] lc_identifier;
  logic         lc_done;
  logic         lc_success;
  logic [2:0]   lc_state;

  int checks = 0;
  int errors = 0;
  int m_fails;
  bit m_locked;

  lc_transition_initiator #(
    .LC_MEMORY_WIDTH (W),
    .MAX_FAILS       (MAXF),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_identifier        (cmd_identifier),
    .cmd_expected_state    (cmd_expected_state),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_status            (rsp_status),
    .rsp_state             (rsp_state),
    .locked                (locked),
    .fault                 (fault),
    .lc_transition_request (lc_transition_request),
    .lc_identifier         (lc_identifier),
    .lc_done               (lc_done),
    .lc_success            (lc_success),
    .lc_state              (lc_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Owner signature the protection block accepts for a given lifecycle state.
  function automatic logic [W-1:0] secret(input logic [2:0] s);
    return 32'h5A3C_0F17 ^ ({29'd0, s} * 32'h0101_0101);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    lc_done = 1'b0; lc_success = 1'b0; cmd_identifier = '0; cmd_expected_state = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_locked = 1'b0;
    m_fails  = 0;
  endtask

  // Rule-level prediction; must be called before the command runs.
  task automatic model_cmd(input logic [W-1:0] id, input logic [2:0] exp,
                           output int st, output int rs, output bit acc);
    int s;
    s = int'(lc_state);
    acc = 1'b0;
    rs = s;
    if (m_locked) st = S_LOCKED;
    else if (s != int'(exp)) st = S_STALE;
    else if (s >= 5) st = S_EOL;
    else begin
      acc = 1'b1;
      if (id == secret(lc_state)) begin
        st = S_OK; rs = s + 1; m_fails = 0;
      end else begin
        st = S_AUTH;
        m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
        if (m_fails >= MAXF) m_locked = 1'b1;
      end
    end
  endtask

  // Issues one command, plays the protection block (done after dly request
  // cycles, never if dly<0), holds rsp_ready low for hold cycles, then takes it.
  task automatic run_cmd(input logic [W-1:0] id, input logic [2:0] exp, input int dly,
                         input int hold, output int st, output int rs,
                         output int reqc, output int lat);
    int cnt;
    int unstable;
    bit got;
    reqc = 0; lat = -1; st = -1; rs = -1; cnt = 0; got = 1'b0; unstable = 0;
    chk("cmd_ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_identifier = id; cmd_expected_state = exp;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_identifier = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1; lat = i; st = int'(rsp_status); rs = int'(rsp_state);
      end else begin
        if (lc_transition_request) begin
          reqc++;
          if (dly >= 0 && cnt == dly) begin
            lc_done = 1'b1;
            lc_success = (lc_identifier == secret(lc_state));
            if (lc_success) lc_state = lc_state + 3'd1;
          end
          cnt++;
        end else if (lc_done) begin
          lc_done = 1'b0; lc_success = 1'b0;
        end
        @(negedge clk);
      end
    end
    lc_done = 1'b0; lc_success = 1'b0;
    chk("rsp_within_bound", int'(got), 1);
    chk("id_zero_at_rsp", int'(lc_identifier), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || int'(rsp_status) != st || int'(rsp_state) != rs) unstable++;
    end
    if (hold > 0) chk("rsp_stable_while_stalled", unstable, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_take", int'(rsp_valid), 0);
  endtask

  typedef struct {
    bit         rst;
    logic [2:0] lcs;
    logic [2:0] exp;
    bit         good;
    int         dly;
    int         st;
    int         rs;
    bit         lock;
    bit         req;
  } vec_t;

  initial begin
    vec_t         tbl[15];
    int           st, rs, reqc, lat, mst, mrs, dly, hold;
    bit           macc;
    logic [W-1:0] id;
    logic [2:0]   exp;

    tbl[0]  = '{1'b1, 3'd1, 3'd1, 1'b1, 2, S_OK,     2, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 3'd2, 3'd2, 1'b0, 1, S_AUTH,   2, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'd2, 3'd2, 1'b0, 0, S_AUTH,   2, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 3'd2, 3'd2, 1'b0, 3, S_AUTH,   2, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'd2, 3'd2, 1'b1, 1, S_LOCKED, 2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 3'd3, 1'b1, 1, S_STALE,  2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'd5, 3'd5, 1'b1, 1, S_EOL,    5, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 3'd0, 1'b1, 0, S_OK,     1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 3'd4, 3'd4, 1'b1, 4, S_OK,     5, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 3'd7, 3'd7, 1'b1, 0, S_EOL,    7, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'd3, 3'd3, 1'b0, 2, S_AUTH,   3, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 3'd3, 3'd3, 1'b1, 1, S_OK,     4, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'd4, 3'd4, 1'b0, 0, S_AUTH,   4, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'd4, 3'd4, 1'b0, 1, S_AUTH,   4, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 3'd4, 3'd4, 1'b0, 2, S_AUTH,   4, 1'b1, 1'b1};

    lc_state = 3'd0;
    do_reset();

    chk("reset_request", int'(lc_transition_request), 0);
    chk("reset_identifier", int'(lc_identifier), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_status", int'(rsp_status), 0);
    chk("reset_rsp_state", int'(rsp_state), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);

    // Stray done while idle must not start anything.
    lc_done = 1'b1; lc_success = 1'b1;
    repeat (3) @(negedge clk);
    lc_done = 1'b0; lc_success = 1'b0;
    chk("idle_done_request", int'(lc_transition_request), 0);
    chk("idle_done_rsp_valid", int'(rsp_valid), 0);
    chk("idle_done_cmd_ready", int'(cmd_ready), 1);

    for (int v = 0; v < 15; v++) begin
      if (tbl[v].rst) do_reset();
      lc_state = tbl[v].lcs;
      id = tbl[v].good ? secret(tbl[v].lcs) : (secret(tbl[v].lcs) ^ 32'h0000_0100);
      run_cmd(id, tbl[v].exp, tbl[v].dly, 0, st, rs, reqc, lat);
      chk($sformatf("vec%0d_status", v), st, tbl[v].st);
      chk($sformatf("vec%0d_rsp_state", v), rs, tbl[v].rs);
      chk($sformatf("vec%0d_locked", v), int'(locked), int'(tbl[v].lock));
      chk($sformatf("vec%0d_req_cycles", v), reqc, tbl[v].req ? tbl[v].dly + 1 : 0);
      chk($sformatf("vec%0d_latency", v), lat, tbl[v].req ? tbl[v].dly + 2 : 0);
    end

    // Response held while the host stalls for 10 cycles.
    do_reset();
    lc_state = 3'd1;
    run_cmd(secret(3'd1), 3'd1, 1, 10, st, rs, reqc, lat);
    chk("stall_status", st, S_OK);
    chk("stall_rsp_state", rs, 2);

    // Asynchronous reset in the middle of a request.
    do_reset();
    lc_state = 3'd2;
    cmd_valid = 1'b1; cmd_identifier = secret(3'd2); cmd_expected_state = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreq_request_high", int'(lc_transition_request), 1);
    chk("midreq_identifier", int'(lc_identifier), int'(secret(3'd2)));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_request", int'(lc_transition_request), 0);
    chk("async_rst_identifier", int'(lc_identifier), 0);
    chk("async_rst_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_locked = 1'b0; m_fails = 0;

    for (int k = 0; k < 48; k++) begin
      if (k % 8 == 0) do_reset();
      if ($urandom_range(0, 3) == 0) lc_state = 3'($urandom_range(0, 7));
      exp  = ($urandom_range(0, 3) != 0) ? lc_state : 3'($urandom_range(0, 7));
      id   = secret(lc_state) ^ (($urandom_range(0, 9) < 7) ? 32'd0 : 32'($urandom_range(1, 255)));
      dly  = int'($urandom_range(0, 4));
      hold = int'($urandom_range(0, 2));
      model_cmd(id, exp, mst, mrs, macc);
      run_cmd(id, exp, dly, hold, st, rs, reqc, lat);
      chk("rand_status", st, mst);
      chk("rand_rsp_state", rs, mrs);
      chk("rand_locked", int'(locked), int'(m_locked));
      chk("rand_req_cycles", reqc, macc ? dly + 1 : 0);
    end

    // Unanswered request: timeout is terminal.
    do_reset();
    lc_state = 3'd1;
    run_cmd(secret(3'd1), 3'd1, -1, 3, st, rs, reqc, lat);
    chk("timeout_req_cycles", reqc, TMO);
    chk("timeout_latency", lat, TMO);
    chk("timeout_status", st, S_TMO);
    chk("timeout_fault", int'(fault), 1);
    cmd_valid = 1'b1; cmd_identifier = secret(3'd1); cmd_expected_state = 3'd1;
    reqc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_ready || lc_transition_request || rsp_valid) reqc++;
    end
    cmd_valid = 1'b0;
    chk("fault_terminal", reqc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
